// File: rtl/packetizer_pkg.sv
// Shared types and constants for the ADC sample packetizer.
// Contents: frame FSM state type, default sync byte, frame length helper.
package packetizer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        SEQ,
        DATA,
        CSUM
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Bytes per frame: sync, sequence, two bytes per channel, checksum.
    function automatic int unsigned frame_len(input int unsigned num_channels);
        return 3 + 2 * num_channels;
    endfunction

endpackage

// File: rtl/sample_packetizer.sv
// Serializes one multi-channel ADC sample set per input handshake into a framed
// byte stream: SYNC, SEQ, ch0 hi/lo, ch1 hi/lo, ..., CSUM (XOR of SEQ and data).
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   s_axis_tdata/tvalid/tready  sample set input (channel k at [k*SAMPLE_WIDTH +: SAMPLE_WIDTH])
//   m_axis_tdata/tvalid/tready  8-bit frame byte output toward the FIFO bridge
//   m_axis_tlast                marks the checksum byte
module sample_packetizer
    import packetizer_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned SAMPLE_WIDTH = 12,
    parameter logic [7:0]  SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_axis_tdata,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    output logic [7:0]                           m_axis_tdata,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast
);

    localparam int unsigned IN_W           = NUM_CHANNELS * SAMPLE_WIDTH;
    localparam int unsigned NUM_DATA_BYTES = frame_len(NUM_CHANNELS) - 3;
    localparam int unsigned IDX_W          = $clog2(NUM_DATA_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DATA_BYTES - 1);

    state_t            state;
    logic [IN_W-1:0]   sample_q;
    logic [7:0]        seq_q;
    logic [7:0]        csum_q;
    logic [IDX_W-1:0]  byte_idx;
    logic [IDX_W-1:0]  byte_idx_nxt;

    // Wire-order data bytes of the held sample set: each channel zero-extended
    // to 16 bits, high byte first.
    logic [7:0] data_bytes [NUM_DATA_BYTES];

    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_bytes
        logic [15:0] word_c;
        assign word_c              = 16'(sample_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]);
        assign data_bytes[2*k]     = word_c[15:8];
        assign data_bytes[2*k + 1] = word_c[7:0];
    end

    assign byte_idx_nxt  = byte_idx + IDX_W'(1);

    // Only IDLE accepts; low throughout the frame so backpressure reaches upstream.
    assign s_axis_tready = (state == IDLE) && !rst;

    // Frame FSM; every transition advances on the current byte's handshake, so
    // data/last hold while stalled and valid never drops mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            sample_q      <= '0;
            seq_q         <= '0;
            csum_q        <= '0;
            byte_idx      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        sample_q      <= s_axis_tdata;
                        m_axis_tdata  <= SYNC_BYTE;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        state         <= SYNC;
                    end
                end
                SYNC: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= seq_q;
                        csum_q       <= seq_q;
                        state        <= SEQ;
                    end
                end
                SEQ: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= data_bytes[0];
                        csum_q       <= csum_q ^ data_bytes[0];
                        byte_idx     <= '0;
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (m_axis_tready) begin
                        if (byte_idx == LAST_IDX) begin
                            // Accumulator already holds every presented data byte.
                            m_axis_tdata <= csum_q;
                            m_axis_tlast <= 1'b1;
                            byte_idx     <= '0;
                            state        <= CSUM;
                        end else begin
                            m_axis_tdata <= data_bytes[byte_idx_nxt];
                            csum_q       <= csum_q ^ data_bytes[byte_idx_nxt];
                            byte_idx     <= byte_idx_nxt;
                        end
                    end
                end
                CSUM: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                        seq_q         <= seq_q + 8'd1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
